// File: rtl/vc_pop_scheduler.sv
// ---------------------------------------------------------------------------
// vc_pop_scheduler
//
// Decides each cycle whether to pop the VC0 or the VC1 FIFO that feeds the
// VC-to-destination arbiter. VC0 and VC1 share the destination FIFOs by
// weighted round-robin. Destination credits are tracked so that the D0 and D1
// FIFOs never fill beyond D_THRESH. A word's destination is only known after
// it has been read, so every pop reserves one slot in both destinations
// until the arbiter pushes the word.
//
// Parameters
//   D_THRESH    limit on occupancy plus in-flight words per destination
//   CNT_W       width of the destination occupancy counters
//   VC0_WEIGHT  maximum consecutive VC0 pops while VC1 is waiting (1..7)
//
// Ports
//   clk                           rising-edge clock
//   reset_L                       asynchronous active-low reset
//   VC0_empty, VC1_empty          VC FIFO empty flags
//   D0_push, D1_push              arbiter pushes into D0/D1 (word completed)
//   D0_pop, D1_pop                downstream pops of D0/D1 (credit returned)
//   pop_VC0, pop_VC1              combinational pop strobes, mutually exclusive
//   pop_delay_VC0, pop_delay_VC1  pop strobes delayed one cycle (data valid)
//   occ_D0, occ_D1                tracked destination occupancies
//   idle                          nothing queued, in flight or stored
//   err                           sticky protocol-error flag
// ---------------------------------------------------------------------------
module vc_pop_scheduler #(
    parameter int D_THRESH   = 6,
    parameter int CNT_W      = 4,
    parameter int VC0_WEIGHT = 3
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             VC0_empty,
    input  logic             VC1_empty,
    input  logic             D0_push,
    input  logic             D1_push,
    input  logic             D0_pop,
    input  logic             D1_pop,
    output logic             pop_VC0,
    output logic             pop_VC1,
    output logic             pop_delay_VC0,
    output logic             pop_delay_VC1,
    output logic [CNT_W-1:0] occ_D0,
    output logic [CNT_W-1:0] occ_D1,
    output logic             idle,
    output logic             err
);

    localparam int SUM_W = CNT_W + 1;

    logic [1:0]       inflight_reg, inflight_next;
    logic [2:0]       wrr_cnt_reg, wrr_cnt_next;
    logic             pop_delay_vc0_reg, pop_delay_vc1_reg;
    logic             err_reg, err_next;

    logic [SUM_W-1:0] sum_d0, sum_d1;
    logic             ok;
    logic             sel_vc0;
    logic             any_pop;
    logic             completion;
    logic             infl_err;
    logic             dual_push;

    // -----------------------------------------------------------------------
    // Per-destination occupancy counters. Each one holds its value and flags
    // an error rather than wrapping on underflow or overflow.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_dest
        logic             push_i;
        logic             pop_i;
        logic [CNT_W-1:0] occ_reg;
        logic [CNT_W-1:0] occ_next;
        logic             dest_err;

        assign push_i = (gi == 0) ? D0_push : D1_push;
        assign pop_i  = (gi == 0) ? D0_pop  : D1_pop;

        always_comb begin
            occ_next = occ_reg;
            dest_err = 1'b0;
            if (push_i && !pop_i) begin
                if (occ_reg == '1) begin
                    dest_err = 1'b1;
                end else begin
                    occ_next = occ_reg + CNT_W'(1);
                end
            end else if (pop_i && !push_i) begin
                if (occ_reg == '0) begin
                    dest_err = 1'b1;
                end else begin
                    occ_next = occ_reg - CNT_W'(1);
                end
            end else if (pop_i && push_i && occ_reg == '0) begin
                // Count is unchanged, but the pop still named an empty FIFO.
                dest_err = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                occ_reg <= '0;
            end else begin
                occ_reg <= occ_next;
            end
        end
    end

    assign occ_D0 = g_dest[0].occ_reg;
    assign occ_D1 = g_dest[1].occ_reg;

    // -----------------------------------------------------------------------
    // Space check and VC selection
    // -----------------------------------------------------------------------
    always_comb begin
        // Sums are one bit wider than the counters so they cannot wrap.
        sum_d0 = {1'b0, occ_D0} + SUM_W'(inflight_reg);
        sum_d1 = {1'b0, occ_D1} + SUM_W'(inflight_reg);
        ok     = (sum_d0 < SUM_W'(D_THRESH)) && (sum_d1 < SUM_W'(D_THRESH));

        // VC0 wins unless VC1 is waiting and VC0 has used up its weight.
        sel_vc0 = !VC0_empty && (VC1_empty || (wrr_cnt_reg < 3'(VC0_WEIGHT)));

        // The pops are gated by reset_L because the FIFOs share that reset.
        pop_VC0 = reset_L && ok && sel_vc0;
        pop_VC1 = reset_L && ok && !VC1_empty && !sel_vc0;
        any_pop = pop_VC0 || pop_VC1;
    end

    // -----------------------------------------------------------------------
    // Round-robin counter, in-flight tracking and error detection
    // -----------------------------------------------------------------------
    always_comb begin
        wrr_cnt_next = wrr_cnt_reg;
        if (VC1_empty || pop_VC1) begin
            wrr_cnt_next = 3'd0;
        end else if (pop_VC0 && wrr_cnt_reg != 3'd7) begin
            wrr_cnt_next = wrr_cnt_reg + 3'd1;
        end
    end

    always_comb begin
        // A push to both destinations in one cycle completes only one word.
        completion    = D0_push || D1_push;
        dual_push     = D0_push && D1_push;
        infl_err      = completion && (inflight_reg == 2'd0);
        inflight_next = inflight_reg;
        if (any_pop && !completion) begin
            if (inflight_reg != 2'd3) begin
                inflight_next = inflight_reg + 2'd1;
            end
        end else if (completion && !any_pop) begin
            if (inflight_reg != 2'd0) begin
                inflight_next = inflight_reg - 2'd1;
            end
        end
        err_next = err_reg || g_dest[0].dest_err || g_dest[1].dest_err
                   || infl_err || dual_push;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            inflight_reg      <= 2'd0;
            wrr_cnt_reg       <= 3'd0;
            pop_delay_vc0_reg <= 1'b0;
            pop_delay_vc1_reg <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            inflight_reg      <= inflight_next;
            wrr_cnt_reg       <= wrr_cnt_next;
            pop_delay_vc0_reg <= pop_VC0;
            pop_delay_vc1_reg <= pop_VC1;
            err_reg           <= err_next;
        end
    end

    assign pop_delay_VC0 = pop_delay_vc0_reg;
    assign pop_delay_VC1 = pop_delay_vc1_reg;
    assign err           = err_reg;
    assign idle          = VC0_empty && VC1_empty && (inflight_reg == 2'd0)
                           && (occ_D0 == '0) && (occ_D1 == '0);

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for vc_pop_scheduler. The bench models the VC FIFOs as queues of
// destination bits, plays the arbiter (push two cycles after a pop) and the
// downstream consumers, and keeps its own occupancy/error model. The expected
// pop for every cycle is queued as each scenario is loaded and popped when
// the cycle is sampled.
// ---------------------------------------------------------------------------
module tb_vc_pop_scheduler;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       VC0_empty, VC1_empty;
    logic       D0_push, D1_push, D0_pop, D1_pop;
    logic       pop_VC0, pop_VC1, pop_delay_VC0, pop_delay_VC1;
    logic [3:0] occ_D0, occ_D1;
    logic       idle, err;

    always #5 clk = ~clk;

    vc_pop_scheduler #(
        .D_THRESH  (6),
        .CNT_W     (4),
        .VC0_WEIGHT(3)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .VC0_empty    (VC0_empty),
        .VC1_empty    (VC1_empty),
        .D0_push      (D0_push),
        .D1_push      (D1_push),
        .D0_pop       (D0_pop),
        .D1_pop       (D1_pop),
        .pop_VC0      (pop_VC0),
        .pop_VC1      (pop_VC1),
        .pop_delay_VC0(pop_delay_VC0),
        .pop_delay_VC1(pop_delay_VC1),
        .occ_D0       (occ_D0),
        .occ_D1       (occ_D1),
        .idle         (idle),
        .err          (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit vc0_q[$];
    bit vc1_q[$];
    int exp_q[$];            // per cycle: 0 no pop, 1 VC0, 2 VC1

    bit s1_v, s1_d, s2_v, s2_d;  // arbiter pipeline: read stage, push stage
    int m_occ0, m_occ1;
    bit m_err;
    bit prev0, prev1;
    bit drain, force_pop0, force_pop1, pop0_at3;

    int wrr_pat[11] = '{1, 1, 1, 2, 1, 1, 1, 2, 1, 1, 2};

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int code, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(code);
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic tick();
        int code;
        bit got_v;
        bit got_d;
        VC0_empty = (vc0_q.size() == 0);
        VC1_empty = (vc1_q.size() == 0);
        D0_push   = s2_v && !s2_d;
        D1_push   = s2_v && s2_d;
        D0_pop    = (drain && m_occ0 > 0) || force_pop0
                    || (pop0_at3 && D0_push && m_occ0 == 3);
        D1_pop    = (drain && m_occ1 > 0) || force_pop1;
        if (pop0_at3 && D0_pop) pop0_at3 = 1'b0;
        force_pop0 = 1'b0;
        force_pop1 = 1'b0;

        #4;  // falling edge
        code = pop_VC0 ? 1 : (pop_VC1 ? 2 : 0);
        chk("pop_exclusive", int'(pop_VC0 && pop_VC1), 0);
        if (exp_q.size() > 0) chk("pop_sel", code, exp_q.pop_front());
        chk("pop_delay_VC0", int'(pop_delay_VC0), int'(prev0));
        chk("pop_delay_VC1", int'(pop_delay_VC1), int'(prev1));
        chk("occ_D0", int'(occ_D0), m_occ0);
        chk("occ_D1", int'(occ_D1), m_occ1);
        chk("err", int'(err), int'(m_err));

        got_v = 1'b0;
        got_d = 1'b0;
        if (pop_VC0) begin
            chk("vc0_had_data", int'(vc0_q.size() > 0), 1);
            if (vc0_q.size() > 0) begin
                got_v = 1'b1;
                got_d = vc0_q.pop_front();
            end
            $display("cyc=%0d pop VC0 dest=D%0d occ=%0d/%0d", cyc, got_d, occ_D0, occ_D1);
        end else if (pop_VC1) begin
            chk("vc1_had_data", int'(vc1_q.size() > 0), 1);
            if (vc1_q.size() > 0) begin
                got_v = 1'b1;
                got_d = vc1_q.pop_front();
            end
            $display("cyc=%0d pop VC1 dest=D%0d occ=%0d/%0d", cyc, got_d, occ_D0, occ_D1);
        end
        prev0 = pop_VC0;
        prev1 = pop_VC1;

        if (reset_L) begin
            if (D0_push && !D0_pop) begin
                if (m_occ0 == 15) m_err = 1'b1; else m_occ0++;
            end else if (D0_pop && !D0_push) begin
                if (m_occ0 == 0) m_err = 1'b1; else m_occ0--;
            end else if (D0_pop && D0_push && m_occ0 == 0) begin
                m_err = 1'b1;
            end
            if (D1_push && !D1_pop) begin
                if (m_occ1 == 15) m_err = 1'b1; else m_occ1++;
            end else if (D1_pop && !D1_push) begin
                if (m_occ1 == 0) m_err = 1'b1; else m_occ1--;
            end else if (D1_pop && D1_push && m_occ1 == 0) begin
                m_err = 1'b1;
            end
            if (D0_push && D1_push) m_err = 1'b1;
        end

        @(posedge clk);
        #1;
        s2_v = s1_v;
        s2_d = s1_d;
        s1_v = got_v;
        s1_d = got_d;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asserts reset between clock edges and checks that it acts at once.
    task automatic do_reset();
        reset_L = 1'b0;
        vc0_q.delete();
        vc1_q.delete();
        exp_q.delete();
        s1_v = 0; s1_d = 0; s2_v = 0; s2_d = 0;
        m_occ0 = 0; m_occ1 = 0; m_err = 0;
        prev0 = 0; prev1 = 0;
        drain = 0; force_pop0 = 0; force_pop1 = 0; pop0_at3 = 0;
        VC0_empty = 1'b1; VC1_empty = 1'b1;
        D0_push = 1'b0; D1_push = 1'b0; D0_pop = 1'b0; D1_pop = 1'b0;
        #1;
        chk("rst_occ_D0", int'(occ_D0), 0);
        chk("rst_occ_D1", int'(occ_D1), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pop_delay_VC0", int'(pop_delay_VC0), 0);
        chk("rst_pop_delay_VC1", int'(pop_delay_VC1), 0);
        chk("rst_idle", int'(idle), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L   = 1'b0;
        VC0_empty = 1'b1;
        VC1_empty = 1'b1;
        D0_push   = 1'b0;
        D1_push   = 1'b0;
        D0_pop    = 1'b0;
        D1_pop    = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with both VCs loaded, then WRR with free-flowing credits
        do_reset();
        for (int i = 0; i < 8; i++) vc0_q.push_back(bit'(i % 2));
        for (int i = 0; i < 3; i++) vc1_q.push_back(bit'((i + 1) % 2));
        drain = 1'b1;
        push_exp(0, 2);
        run(2);
        reset_L = 1'b1;
        foreach (wrr_pat[i]) exp_q.push_back(wrr_pat[i]);
        push_exp(0, 5);
        run(16);
        chk("wrr_idle", int'(idle), 1);

        // VC1-only stream, destinations D1,D0,D1,D1, no downstream pops
        do_reset();
        vc1_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        push_exp(0, 1);
        run(1);
        reset_L = 1'b1;
        push_exp(2, 4);
        push_exp(0, 4);
        run(8);
        chk("single_occ_D0", int'(occ_D0), 1);
        chk("single_occ_D1", int'(occ_D1), 3);
        chk("single_idle", int'(idle), 0);

        // Back-pressure: everything to D0, nothing drained
        do_reset();
        for (int i = 0; i < 10; i++) vc0_q.push_back(1'b0);
        push_exp(0, 1);
        run(1);
        reset_L = 1'b1;
        push_exp(1, 6);
        push_exp(0, 4);
        run(10);
        chk("bp_occ_full", int'(occ_D0), 6);
        force_pop0 = 1'b1;
        push_exp(0, 1);
        push_exp(1, 1);
        push_exp(0, 3);
        run(5);
        chk("bp_occ_after_credit", int'(occ_D0), 6);
        chk("bp_vc0_left", vc0_q.size(), 3);

        // Push and pop of D0 in the same cycle at occupancy 3
        do_reset();
        for (int i = 0; i < 4; i++) vc0_q.push_back(1'b0);
        pop0_at3 = 1'b1;
        push_exp(0, 1);
        run(1);
        reset_L = 1'b1;
        push_exp(1, 4);
        push_exp(0, 4);
        run(8);
        chk("simul_hit", int'(pop0_at3), 0);
        chk("simul_occ_D0", int'(occ_D0), 3);

        // Underflow: D1_pop with D1 empty
        do_reset();
        push_exp(0, 1);
        run(1);
        reset_L = 1'b1;
        force_pop1 = 1'b1;
        push_exp(0, 4);
        run(4);
        chk("uflow_occ_D1", int'(occ_D1), 0);
        chk("uflow_err_sticky", int'(err), 1);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
